compression_engine_tdm: RTL and testbench
=========================================

// Module: compression_engine_tdm
// PURPOSE
// - Next-generation per-board compression front end.
// - Processes Num_channels time-multiplexed ultrasound channels over one sample bus.
// - Per-channel path: fs/4 IQ demodulation, then boxcar LPF+decimation, then optional requantization.
// - Results go into an output FIFO with a valid/ready handshake toward the packetiser / link.
// - Mode is run-time selectable and switches only on frame boundaries.
// PARAMETERS
// - Data_width        10  signed sample width (input and I/Q output)
// - Num_channels      4   interleaved channels per sample period (>=2)
// - Decimation_factor 2   samples averaged per output; power of 2, >=2
// - Requantized_bits  6   output precision in mode 2; < Data_width
// - Fifo_depth        8   output FIFO entries; power of 2
// PORTS
// - clk_i            in   1                       single system clock
// - reset_ni         in   1                       asynchronous, active-low reset
// - mode_i           in   2                       0 bypass, 1 IQ+decimate, 2 IQ+decimate+requant, 3 = 0
// - data_i           in   Data_width              signed input sample
// - data_valid_i     in   1                       data_i valid this cycle
// - channel_start_i  in   1                       qualifies data_i as channel 0 of a frame
// - I_data_o         out  Data_width              FIFO head, I component (signed)
// - Q_data_o         out  Data_width              FIFO head, Q component (signed)
// - channel_o        out  $clog2(Num_channels)    channel index of FIFO head
// - data_valid_o     out  1                       FIFO not empty
// - data_ready_i     in   1                       consumer accepts head when data_valid_o=1
// - overflow_o       out  1                       sticky: a result was dropped on a full FIFO
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, ch counter 0; all phase/decimation counters and accumulators 0; mode_q=0.
// - Reset asserted mid-operation clears everything immediately; no partial results survive.
// - Channel counter advances on data_valid_i only.
// -   channel_start_i=1: sample is ch0 (counter resyncs to 1).
// -   Otherwise: sample is ch(counter); counter wraps Num_channels-1 -> 0.
// - mode_q: mode_i latched only on valid && channel_start_i.
// -   On a mode change, all per-channel phases, dec counters and accumulators clear before that sample.
// - Per channel: 2-bit mixer phase p, advances on each of that channel's samples.
// -   p=0: I=x,  Q=0
// -   p=1: I=0,  Q=-x
// -   p=2: I=-x, Q=0
// -   p=3: I=0,  Q=x
// -   Negation saturates: -(-2^(W-1)) = 2^(W-1)-1.
// - Per channel: I/Q accumulators of width Data_width+log2(D), plus dec counter 0..D-1.
// -   At count D-1: result = (acc + new) >>> log2(D) (arithmetic); push result; clear acc and counter.
// - Mode 0: I=x, Q=0; every sample pushed; no accumulation.
// - Mode 2: each decimated I/Q is rounded half-up and saturated to Requantized_bits.
// -   Shift is >>> (W-R); result is sign-extended into Data_width.
// - Latency: input sample to FIFO push is exactly 2 cycles (mix register, accumulate/output register).
// - FIFO:
// -   Pop when data_valid_o && data_ready_i.
// -   Push when full and no pop: result dropped; overflow_o=1 next cycle and held until reset.
// -   Simultaneous push+pop when full: both occur, no drop.
// -   Push on empty: data_valid_o=1 the following cycle; outputs are registered FIFO head.
// - Ordering preserved; channel_o travels with each entry.
// CONFIGURATION
// - Macro COMPRESSION_DROP_CNT_EN.
// -   Defined: adds output port drop_count_o[15:0], reset 0, +1 per dropped result, saturates at 16'hFFFF.
// -   Undefined: port absent, only sticky overflow_o; datapath otherwise identical.
// TESTING (defaults unless stated, data_ready_i=1)
// - Mode 0: ch0..3 = 5,-3,7,0 (start on ch0).
// -   -> I=5,-3,7,0, Q=0, channel_o=0..3.
// -   Each appears 3 cycles after input (2 to push + 1 FIFO).
// - Mode 1: all channels x=100 for 4 frames.
// -   -> per channel (I,Q) = (50,-50) then (-50,50); 8 outputs total.
// - Mode 1, x=-512 at p=1 with x=0 at p=0.
// -   -> Q contribution saturates to 511; Q_out=(0+511)>>>1=255.
// - Mode 2, W=10, R=6.
// -   Decimated 50 -> 3; -50 -> -3; 511 -> saturates to 31; -512 -> -32.
// - data_ready_i=0, mode 0, 10 samples.
// -   -> 8 stored; overflow_o rises after 9th push; draining yields first 8 in order.
// -   With macro: drop_count_o=2.
// - mode_i 0->1 at ch2 mid-frame.
// -   -> mode 0 output until next channel_start_i.
// -   Reset pulse mid-frame -> data_valid_o=0, FIFO empty, overflow_o=0.

Source files
------------

// File: rtl/compression_engine_tdm.sv
// TDM ultrasound compression front end: fs/4 IQ mixer, boxcar decimator, optional requantizer, output FIFO.
// Optional macro COMPRESSION_DROP_CNT_EN adds a saturating drop_count_o[15:0] port.
module compression_engine_tdm #(
    parameter int  Data_width        = 10,
    parameter int  Num_channels      = 4,
    parameter int  Decimation_factor = 2,
    parameter int  Requantized_bits  = 6,
    parameter int  Fifo_depth        = 8,
    localparam int Ch_w              = $clog2(Num_channels)
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic [1:0]                   mode_i,
    input  logic signed [Data_width-1:0] data_i,
    input  logic                         data_valid_i,
    input  logic                         channel_start_i,
    output logic signed [Data_width-1:0] I_data_o,
    output logic signed [Data_width-1:0] Q_data_o,
    output logic [Ch_w-1:0]              channel_o,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    output logic                         overflow_o
`ifdef COMPRESSION_DROP_CNT_EN
    ,
    output logic [15:0]                  drop_count_o
`endif
);

    localparam int Dec_log   = $clog2(Decimation_factor);
    localparam int Acc_w     = Data_width + Dec_log;
    localparam int Ptr_w     = $clog2(Fifo_depth);
    localparam int Req_shift = Data_width - Requantized_bits;

    typedef logic signed [Data_width-1:0] sample_t;
    typedef logic signed [Acc_w-1:0]      acc_t;
    typedef logic signed [Data_width:0]   wide_t;
    typedef logic [Dec_log-1:0]           dec_cnt_t;

    typedef enum logic [1:0] {
        MODE_BYPASS     = 2'd0,
        MODE_DECIM      = 2'd1,
        MODE_REQUANT    = 2'd2,
        MODE_BYPASS_ALT = 2'd3
    } mode_e;

    typedef struct packed {
        sample_t         i;
        sample_t         q;
        logic [Ch_w-1:0] ch;
    } entry_t;

    localparam sample_t Sample_min = {1'b1, {(Data_width-1){1'b0}}};
    localparam sample_t Sample_max = {1'b0, {(Data_width-1){1'b1}}};
    localparam wide_t   Round_half = wide_t'(1) <<< (Req_shift - 1);
    localparam wide_t   Req_max    = wide_t'((2 ** (Requantized_bits - 1)) - 1);
    localparam wide_t   Req_min    = wide_t'(-(2 ** (Requantized_bits - 1)));

    function automatic sample_t sat_neg(sample_t v);
        if (v == Sample_min) return Sample_max;
        return -v;
    endfunction

    // Round half-up by adding half an output LSB, then arithmetic shift and clamp.
    function automatic sample_t requant(sample_t v);
        wide_t rounded;
        wide_t shifted;
        rounded = wide_t'(v) + Round_half;
        shifted = rounded >>> Req_shift;
        if (shifted > Req_max) shifted = Req_max;
        if (shifted < Req_min) shifted = Req_min;
        return sample_t'(shifted);
    endfunction

    // ---------------- Input / mixer stage ----------------
    logic [Ch_w-1:0] ch_cnt;
    mode_e           mode_q;
    logic [1:0]      phase [Num_channels];

    logic            start_s;
    logic            mode_change;
    logic            use_iq;
    mode_e           eff_mode;
    logic [Ch_w-1:0] in_ch;
    logic [1:0]      in_phase;
    sample_t         neg_x;
    sample_t         mix_i;
    sample_t         mix_q;

    logic            s1_valid;
    logic            s1_clear;
    logic            s1_iq;
    logic            s1_requant;
    logic [Ch_w-1:0] s1_ch;
    sample_t         s1_i;
    sample_t         s1_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        start_s     = data_valid_i && channel_start_i;
        eff_mode    = start_s ? mode_e'(mode_i) : mode_q;
        mode_change = start_s && (mode_e'(mode_i) != mode_q);
        use_iq      = (eff_mode == MODE_DECIM) || (eff_mode == MODE_REQUANT);
        in_ch       = channel_start_i ? '0 : ch_cnt;
        in_phase    = mode_change ? 2'd0 : phase[in_ch];
        neg_x       = sat_neg(data_i);
        mix_i       = data_i;
        mix_q       = '0;
        if (use_iq) begin
            case (in_phase)
                2'd1:    begin mix_i = '0;    mix_q = neg_x;  end
                2'd2:    begin mix_i = neg_x; mix_q = '0;     end
                2'd3:    begin mix_i = '0;    mix_q = data_i; end
                default: begin mix_i = data_i; mix_q = '0;    end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ch_cnt     <= '0;
            mode_q     <= MODE_BYPASS;
            s1_valid   <= 1'b0;
            s1_clear   <= 1'b0;
            s1_iq      <= 1'b0;
            s1_requant <= 1'b0;
            s1_ch      <= '0;
            s1_i       <= '0;
            s1_q       <= '0;
            for (int c = 0; c < Num_channels; c++) phase[c] <= 2'd0;
        end else begin
            s1_valid <= data_valid_i;
            s1_clear <= mode_change;
            if (data_valid_i) begin
                if (channel_start_i)                         ch_cnt <= Ch_w'(1);
                else if (ch_cnt == Ch_w'(Num_channels - 1)) ch_cnt <= '0;
                else                                         ch_cnt <= ch_cnt + Ch_w'(1);
                s1_ch      <= in_ch;
                s1_i       <= mix_i;
                s1_q       <= mix_q;
                s1_iq      <= use_iq;
                s1_requant <= (eff_mode == MODE_REQUANT);
                if (mode_change)
                    for (int c = 0; c < Num_channels; c++) phase[c] <= 2'd0;
                if (use_iq) phase[in_ch] <= in_phase + 2'd1;
            end
            if (start_s) mode_q <= mode_e'(mode_i);
        end
    end

    // ---------------- Accumulate / decimate stage ----------------
    acc_t     acc_i   [Num_channels];
    acc_t     acc_q   [Num_channels];
    dec_cnt_t dec_cnt [Num_channels];

    acc_t     base_i;
    acc_t     base_q;
    dec_cnt_t base_cnt;
    acc_t     sum_i;
    acc_t     sum_q;
    sample_t  avg_i;
    sample_t  avg_q;
    sample_t  res_i;
    sample_t  res_q;
    logic     dec_done;

    logic     push_valid;
    entry_t   push_entry;

    // A mode change flushes history before the flagged sample is folded in.
    always_comb begin
        base_i   = s1_clear ? '0 : acc_i[s1_ch];
        base_q   = s1_clear ? '0 : acc_q[s1_ch];
        base_cnt = s1_clear ? '0 : dec_cnt[s1_ch];
        sum_i    = base_i + acc_t'(s1_i);
        sum_q    = base_q + acc_t'(s1_q);
        avg_i    = sample_t'(sum_i >>> Dec_log);
        avg_q    = sample_t'(sum_q >>> Dec_log);
        res_i    = s1_requant ? requant(avg_i) : avg_i;
        res_q    = s1_requant ? requant(avg_q) : avg_q;
        dec_done = (base_cnt == dec_cnt_t'(Decimation_factor - 1));
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            push_valid <= 1'b0;
            push_entry <= '0;
            for (int c = 0; c < Num_channels; c++) begin
                acc_i[c]   <= '0;
                acc_q[c]   <= '0;
                dec_cnt[c] <= '0;
            end
        end else begin
            push_valid <= 1'b0;
            if (s1_valid) begin
                if (s1_clear) begin
                    for (int c = 0; c < Num_channels; c++) begin
                        acc_i[c]   <= '0;
                        acc_q[c]   <= '0;
                        dec_cnt[c] <= '0;
                    end
                end
                if (!s1_iq) begin
                    push_valid <= 1'b1;
                    push_entry <= '{i: s1_i, q: s1_q, ch: s1_ch};
                end else if (dec_done) begin
                    push_valid     <= 1'b1;
                    push_entry     <= '{i: res_i, q: res_q, ch: s1_ch};
                    acc_i[s1_ch]   <= '0;
                    acc_q[s1_ch]   <= '0;
                    dec_cnt[s1_ch] <= '0;
                end else begin
                    acc_i[s1_ch]   <= sum_i;
                    acc_q[s1_ch]   <= sum_q;
                    dec_cnt[s1_ch] <= base_cnt + dec_cnt_t'(1);
                end
            end
        end
    end

    // ---------------- Output FIFO with registered head ----------------
    entry_t         mem [Fifo_depth];
    logic [Ptr_w-1:0] rd_ptr;
    logic [Ptr_w-1:0] wr_ptr;
    logic [Ptr_w:0]   count;
    entry_t           head_q;

    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;
    logic [Ptr_w:0]   count_next;
    logic [Ptr_w-1:0] rd_ptr_next;
    entry_t           head_next;

    always_comb begin
        pop         = data_valid_o && data_ready_i;
        full        = (count == (Ptr_w+1)'(Fifo_depth));
        wr_en       = push_valid && (!full || pop);
        drop        = push_valid && full && !pop;
        count_next  = count + (Ptr_w+1)'(wr_en) - (Ptr_w+1)'(pop);
        rd_ptr_next = rd_ptr + Ptr_w'(pop);
        head_next   = '0;
        // When the stored contents run out, the incoming push becomes the head directly.
        if (count_next != '0)
            head_next = (count == (Ptr_w+1)'(pop)) ? push_entry : mem[rd_ptr_next];
    end

    // NOTE: the storage array has no reset; pointers and count define validity, so stale words are never visible.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            head_q       <= '0;
            data_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            rd_ptr       <= rd_ptr_next;
            if (wr_en) wr_ptr <= wr_ptr + Ptr_w'(1);
            count        <= count_next;
            head_q       <= head_next;
            data_valid_o <= (count_next != '0);
            if (drop) overflow_o <= 1'b1;
        end
    end

    assign I_data_o  = head_q.i;
    assign Q_data_o  = head_q.q;
    assign channel_o = head_q.ch;

`ifdef COMPRESSION_DROP_CNT_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)                            drop_count_o <= 16'd0;
        else if (drop && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_compression_engine_tdm.sv
// Directed, table-driven bench for compression_engine_tdm at default parameters.
module tb_compression_engine_tdm;

    logic              clk_i = 1'b0;
    logic              reset_ni = 1'b0;
    logic [1:0]        mode_i = 2'd0;
    logic signed [9:0] data_i = '0;
    logic              data_valid_i = 1'b0;
    logic              channel_start_i = 1'b0;
    logic signed [9:0] I_data_o;
    logic signed [9:0] Q_data_o;
    logic [1:0]        channel_o;
    logic              data_valid_o;
    logic              data_ready_i = 1'b1;
    logic              overflow_o;
`ifdef COMPRESSION_DROP_CNT_EN
    logic [15:0]       drop_count_o;
`endif

    compression_engine_tdm dut (
        .clk_i           (clk_i),
        .reset_ni        (reset_ni),
        .mode_i          (mode_i),
        .data_i          (data_i),
        .data_valid_i    (data_valid_i),
        .channel_start_i (channel_start_i),
        .I_data_o        (I_data_o),
        .Q_data_o        (Q_data_o),
        .channel_o       (channel_o),
        .data_valid_o    (data_valid_o),
        .data_ready_i    (data_ready_i),
        .overflow_o      (overflow_o)
`ifdef COMPRESSION_DROP_CNT_EN
        ,
        .drop_count_o    (drop_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] mode;
        logic       start;
        int         x;
        bit         has_exp;
        int         ei;
        int         eq;
        int         ech;
    } vec_t;

    typedef struct {
        int i;
        int q;
        int ch;
    } out_t;

    vec_t vecs[$];
    out_t exp_q[$];
    out_t mon_e;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic void add(input logic [1:0] mode, input logic start, input int x,
                                input bit has_exp, input int ei, input int eq, input int ech);
        vecs.push_back('{mode, start, x, has_exp, ei, eq, ech});
    endfunction

    task automatic drive(input logic [1:0] mode, input logic start, input int x);
        logic [31:0] xv;
        xv              = x;
        mode_i          = mode;
        channel_start_i = start;
        data_i          = xv[9:0];
        data_valid_i    = 1'b1;
    endtask

    // In-order scoreboard: each accepted head is compared with the oldest expectation.
    always @(negedge clk_i) begin
        if (mon_en && data_valid_o && data_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output I=%0d Q=%0d ch=%0d expected none",
                         I_data_o, Q_data_o, channel_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_I", int'(I_data_o), mon_e.i);
                check("out_Q", int'(Q_data_o), mon_e.q);
                check("out_ch", int'(channel_o), mon_e.ch);
            end
        end
    end

    initial begin
        // Mode 0 with counter wrap; mode_i changes mid-frame must not take effect.
        add(0, 1, 5,    1, 5,    0, 0);
        add(0, 0, -3,   1, -3,   0, 1);
        add(1, 0, 7,    1, 7,    0, 2);
        add(1, 0, 0,    1, 0,    0, 3);
        add(1, 0, -512, 1, -512, 0, 0);
        add(1, 0, 511,  1, 511,  0, 1);
        // Mode 1: four frames of 100 on every channel.
        for (int f = 0; f < 4; f++)
            for (int c = 0; c < 4; c++)
                add(1, c == 0, 100, (f == 1) || (f == 3),
                    (f == 1) ? 50 : -50, (f == 1) ? -50 : 50, c);
        // Mode 2: requantization of decimated values.
        add(2, 1, 100,  0, 0, 0, 0);
        add(2, 0, 510,  0, 0, 0, 0);
        add(2, 0, -512, 0, 0, 0, 0);
        add(2, 0, -100, 0, 0, 0, 0);
        add(2, 1, -100, 1, 3,   3,  0);
        add(2, 0, 100,  1, 16,  -3, 1);
        add(2, 0, 0,    1, -16, 0,  2);
        add(2, 0, 0,    1, -3,  0,  3);
        // Mode 1: saturating negation of -512 at p=1 and floor shift of -7.
        add(1, 1, 0,    0, 0, 0, 0);
        add(1, 0, 0,    0, 0, 0, 0);
        add(1, 0, 0,    0, 0, 0, 0);
        add(1, 0, 0,    0, 0, 0, 0);
        add(1, 1, -512, 1, 0, 255, 0);
        add(1, 0, 7,    1, 0, -4,  1);
        add(1, 0, 0,    1, 0, 0,   2);
        add(1, 0, 0,    1, 0, 0,   3);

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", int'(data_valid_o), 0);
        check("rst_I", int'(I_data_o), 0);
        check("rst_Q", int'(Q_data_o), 0);
        check("rst_ch", int'(channel_o), 0);
        check("rst_overflow", int'(overflow_o), 0);
`ifdef COMPRESSION_DROP_CNT_EN
        check("rst_drop_count", int'(drop_count_o), 0);
`endif
        reset_ni = 1'b1;
        tick();

        // Latency: one mode-0 sample shows up at the FIFO head three cycles later.
        drive(0, 1, 5);
        tick();
        data_valid_i = 1'b0;
        check("lat_cycle1_valid", int'(data_valid_o), 0);
        tick();
        check("lat_cycle2_valid", int'(data_valid_o), 0);
        tick();
        check("lat_cycle3_valid", int'(data_valid_o), 1);
        check("lat_cycle3_I", int'(I_data_o), 5);
        check("lat_cycle3_ch", int'(channel_o), 0);
        repeat (3) tick();

        // Table-driven stream, back to back.
        mon_en = 1'b1;
        foreach (vecs[k]) begin
            drive(vecs[k].mode, vecs[k].start, vecs[k].x);
            if (vecs[k].has_exp) exp_q.push_back('{vecs[k].ei, vecs[k].eq, vecs[k].ech});
            tick();
        end
        data_valid_i    = 1'b0;
        channel_start_i = 1'b0;
        for (int n = 0; n < 30 && exp_q.size() != 0; n++) tick();
        check("table_outstanding", exp_q.size(), 0);
        tick();
        mon_en = 1'b0;
        check("table_fifo_empty", int'(data_valid_o), 0);

        // Overflow: ten mode-0 samples with the consumer stalled.
        data_ready_i = 1'b0;
        for (int n = 0; n < 10; n++) begin
            drive(0, n == 0, n + 1);
            tick();
        end
        data_valid_i    = 1'b0;
        channel_start_i = 1'b0;
        check("ovf_before_drop", int'(overflow_o), 0);
        tick();
        check("ovf_after_9th_push", int'(overflow_o), 1);
        tick();
`ifdef COMPRESSION_DROP_CNT_EN
        check("ovf_drop_count", int'(drop_count_o), 2);
`endif
        data_ready_i = 1'b1;
        for (int n = 0; n < 8; n++) begin
            check("drain_valid", int'(data_valid_o), 1);
            check("drain_I", int'(I_data_o), n + 1);
            check("drain_ch", int'(channel_o), n % 4);
            tick();
        end
        check("drain_empty", int'(data_valid_o), 0);
        check("drain_overflow_sticky", int'(overflow_o), 1);

        // Reset mid-frame with data stored and a sample in flight.
        data_ready_i = 1'b0;
        drive(0, 1, 3);
        tick();
        drive(0, 0, 4);
        tick();
        data_valid_i    = 1'b0;
        channel_start_i = 1'b0;
        repeat (3) tick();
        check("pre_rst_valid", int'(data_valid_o), 1);
        drive(0, 0, 6);
        tick();
        data_valid_i = 1'b0;
        #2;
        reset_ni = 1'b0;
        #1;
        check("midrst_valid", int'(data_valid_o), 0);
        check("midrst_overflow", int'(overflow_o), 0);
        check("midrst_I", int'(I_data_o), 0);
        #4;
        reset_ni = 1'b1;
        repeat (4) tick();
        check("post_rst_no_residue", int'(data_valid_o), 0);
        drive(0, 0, 9);
        tick();
        data_valid_i = 1'b0;
        repeat (2) tick();
        check("post_rst_valid", int'(data_valid_o), 1);
        check("post_rst_I", int'(I_data_o), 9);
        check("post_rst_ch", int'(channel_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
